slot_demux: RTL and testbench

//  Test-bench helper that de-multiplexes a time-division (channel x operator) slot stream into per-slot registers.

---
 rtl/slot_demux_pkg.sv | 28 ++
 rtl/slot_demux_reduce.sv | 36 +++
 rtl/slot_demux.sv | 108 ++++++++++
 tb/tb_slot_demux.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_demux_pkg.sv
// Shared constants and slot-to-storage index mapping for the slot demultiplexer.
// The mapping function is also used by benches that need to locate a slot in live/snap.
package slot_demux_pkg;

    localparam int DEF_W     = 10;
    localparam int DEF_CH    = 6;
    localparam int DEF_OPS   = 4;
    localparam int DEF_SLOTS = DEF_CH * DEF_OPS;

    function automatic int idx_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    // Stream order within a frame is group-major; on 4-op parts the middle two
    // groups arrive swapped relative to operator numbering.
    function automatic int slot2idx(input int s, input int ch, input int ops, input bit swap23);
        int g, c, op;
        g  = s / ch;
        c  = s % ch;
        op = g;
        if (swap23 && ops == 4) begin
            if (g == 1)      op = 2;
            else if (g == 2) op = 1;
        end
        return op * ch + c;
    endfunction

endpackage

// File: rtl/slot_demux_reduce.sv
// Registered masked AND/OR reduction across all live slot registers.
module slot_demux_reduce #(
    parameter int W     = 10,
    parameter int SLOTS = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SLOTS*W-1:0] live,
    input  logic [SLOTS-1:0]   mask,
    output logic [W-1:0]       alland,
    output logic [W-1:0]       allor
);

    logic [W-1:0] and_c, or_c;

    // Unmasked slots are forced to the identity of each reduction.
    always_comb begin
        and_c = '1;
        or_c  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            and_c = and_c & (live[i*W +: W] | {W{~mask[i]}});
            or_c  = or_c  | (live[i*W +: W] & {W{mask[i]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alland <= '0;
            allor  <= '0;
        end else begin
            alland <= and_c;
            allor  <= or_c;
        end
    end

endmodule

// File: rtl/slot_demux.sv
// Time-division slot stream demultiplexer: marker sync, per-slot capture,
// change flags, frame snapshot handshake and masked reductions.
module slot_demux
    import slot_demux_pkg::*;
#(
    parameter int W      = 10,
    parameter int CH     = 6,
    parameter int OPS    = 4,
    parameter int POS0   = 0,
    parameter bit SWAP23 = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   zero,
    input  logic [W-1:0]           mixed,
    input  logic [CH*OPS-1:0]      mask,
    input  logic                   clr_chg,
    input  logic                   snap_ack,
    output logic [CH*OPS*W-1:0]    live,
    output logic [CH*OPS*W-1:0]    snap,
    output logic                   snap_vld,
    output logic                   overrun,
    output logic                   frame_done,
    output logic [CH*OPS-1:0]      changed,
    output logic                   locked,
    output logic                   sync_err,
    output logic [W-1:0]           alland,
    output logic [W-1:0]           allor
);

    localparam int SLOTS = CH * OPS;
    localparam int CW    = idx_w(SLOTS);

    logic [CW-1:0] cnt;
    logic [CW-1:0] slot;
    logic          mark;
    logic          cap;
    int            idx;

    assign mark = cen & zero;
    assign slot = mark ? CW'(POS0) : cnt;
    // The marker sample itself is captured, so capture is allowed on the locking cycle.
    assign cap  = cen & (locked | zero);

    always_comb idx = slot2idx(int'(slot), CH, OPS, SWAP23);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sync_err   <= mark & locked & (cnt != CW'(POS0));
            frame_done <= cap & (slot == CW'(SLOTS-1));
            if (mark) begin
                locked <= 1'b1;
                cnt    <= CW'((POS0 + 1) % SLOTS);
            end else if (cen) begin
                cnt <= (cnt == CW'(SLOTS-1)) ? '0 : cnt + 1'b1;
            end
        end
    end

    // A new change on a slot wins over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live    <= '0;
            changed <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (cap && idx == i) begin
                    live[i*W +: W] <= mixed;
                    if (live[i*W +: W] != mixed) changed[i] <= 1'b1;
                    else if (clr_chg)            changed[i] <= 1'b0;
                end else if (clr_chg) begin
                    changed[i] <= 1'b0;
                end
            end
        end
    end

    // An ack landing on the frame-end cycle frees the buffer for the new frame.
    assign overrun = frame_done & snap_vld & ~snap_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap     <= '0;
            snap_vld <= 1'b0;
        end else if (frame_done && (!snap_vld || snap_ack)) begin
            snap     <= live;
            snap_vld <= 1'b1;
        end else if (snap_ack) begin
            snap_vld <= 1'b0;
        end
    end

    slot_demux_reduce #(.W(W), .SLOTS(SLOTS)) u_reduce (
        .clk    (clk),
        .rst    (rst),
        .live   (live),
        .mask   (mask),
        .alland (alland),
        .allor  (allor)
    );

endmodule

// File: tb/tb_slot_demux.sv
// Randomised bench for slot_demux against a cycle-level reference model of the slot rules.
module tb_slot_demux;

    localparam int W = 10, CH = 6, OPS = 4, S = 24;
    localparam int CHB = 3, OPSB = 2, SB = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             cen, zero, clr_chg, snap_ack;
    logic [W-1:0]     mixed;
    logic [S-1:0]     mask;
    logic [S*W-1:0]   live, snap;
    logic             snap_vld, overrun, frame_done, locked, sync_err;
    logic [S-1:0]     changed;
    logic [W-1:0]     alland, allor;

    logic             cen_b, zero_b, clr_b, ack_b;
    logic [W-1:0]     mixed_b;
    logic [SB-1:0]    mask_b;
    logic [SB*W-1:0]  live_b, snap_b;
    logic             snap_vld_b, overrun_b, frame_done_b, locked_b, sync_err_b;
    logic [SB-1:0]    changed_b;
    logic [W-1:0]     alland_b, allor_b;

    slot_demux #(.W(W), .CH(CH), .OPS(OPS), .POS0(0), .SWAP23(1'b1)) dut (
        .clk(clk), .rst(rst), .cen(cen), .zero(zero), .mixed(mixed), .mask(mask),
        .clr_chg(clr_chg), .snap_ack(snap_ack), .live(live), .snap(snap),
        .snap_vld(snap_vld), .overrun(overrun), .frame_done(frame_done),
        .changed(changed), .locked(locked), .sync_err(sync_err),
        .alland(alland), .allor(allor));

    slot_demux #(.W(W), .CH(CHB), .OPS(OPSB), .POS0(0), .SWAP23(1'b0)) dut_b (
        .clk(clk), .rst(rst), .cen(cen_b), .zero(zero_b), .mixed(mixed_b), .mask(mask_b),
        .clr_chg(clr_b), .snap_ack(ack_b), .live(live_b), .snap(snap_b),
        .snap_vld(snap_vld_b), .overrun(overrun_b), .frame_done(frame_done_b),
        .changed(changed_b), .locked(locked_b), .sync_err(sync_err_b),
        .alland(alland_b), .allor(allor_b));

    int n_chk = 0, n_pass = 0;

    // reference model state
    int           m_cnt;
    bit           m_locked, m_vld, m_fd;
    logic [W-1:0] m_live [S];
    logic [W-1:0] m_snap [S];
    logic [S-1:0] m_chg;
    int           m_fd_n = 0, m_se_n = 0, m_ovr_n = 0;
    int           fd_n = 0, se_n = 0, ovr_n = 0, fdb_n = 0;
    logic [W-1:0] fr [S];

    function automatic int eidx(input int s);
        int g, c, op;
        g  = s / CH;
        c  = s % CH;
        op = (g == 1) ? 2 : (g == 2) ? 1 : g;
        return op * CH + c;
    endfunction

    function automatic logic [S*W-1:0] exp_live();
        logic [S*W-1:0] r;
        for (int i = 0; i < S; i++) r[i*W +: W] = m_live[i];
        return r;
    endfunction

    function automatic logic [S*W-1:0] exp_snap();
        logic [S*W-1:0] r;
        for (int i = 0; i < S; i++) r[i*W +: W] = m_snap[i];
        return r;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_locked = 0; m_vld = 0; m_fd = 0; m_chg = '0;
        for (int i = 0; i < S; i++) begin m_live[i] = '0; m_snap[i] = '0; end
    endtask

    // One clock of the main DUT with the model stepped alongside it.
    task automatic cyc(input bit c, input bit z, input logic [W-1:0] v, input bit clr, input bit ack);
        bit nfd;
        int sl, k;
        cen = c; zero = z; mixed = v; clr_chg = clr; snap_ack = ack;
        #1;
        if (overrun) ovr_n++;
        if (m_fd && m_vld && !ack) m_ovr_n++;
        if (m_fd && (!m_vld || ack)) begin
            for (int i = 0; i < S; i++) m_snap[i] = m_live[i];
            m_vld = 1;
        end else if (ack) m_vld = 0;
        if (clr) m_chg = '0;
        nfd = 0;
        if (c) begin
            sl = z ? 0 : m_cnt;
            if (z && m_locked && m_cnt != 0) m_se_n++;
            if (z) m_locked = 1;
            if (m_locked) begin
                k = eidx(sl);
                if (m_live[k] !== v) m_chg[k] = 1'b1;
                m_live[k] = v;
                if (sl == S-1) nfd = 1;
            end
            m_cnt = z ? 1 : (m_cnt + 1) % S;
        end
        m_fd = nfd;
        if (nfd) m_fd_n++;
        @(posedge clk); #1;
        if (frame_done) fd_n++;
        if (sync_err) se_n++;
    endtask

    task automatic send_frame(input int clr_at, input bit ack_end);
        for (int s = 0; s < S; s++) cyc(1'b1, s == 0, fr[s], s == clr_at, 1'b0);
        cyc(1'b0, 1'b0, W'($urandom), 1'b0, ack_end);
    endtask

    task automatic cyc_b(input bit c, input bit z, input logic [W-1:0] v);
        cen_b = c; zero_b = z; mixed_b = v;
        @(posedge clk); #1;
        if (frame_done_b) fdb_n++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cen = 0; zero = 0; mixed = '0; mask = '0; clr_chg = 0; snap_ack = 0;
        cen_b = 0; zero_b = 0; mixed_b = '0; mask_b = '0; clr_b = 0; ack_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (live !== '0 || snap !== '0) $display("FAIL reset_data live=%h snap=%h want 0", live, snap); else n_pass++;
        n_chk++; if ({snap_vld, locked, frame_done, sync_err, overrun} !== 5'b0) $display("FAIL reset_flags got=%b want 00000", {snap_vld, locked, frame_done, sync_err, overrun}); else n_pass++;
        n_chk++; if (changed !== '0 || alland !== '0 || allor !== '0) $display("FAIL reset_red chg=%h and=%h or=%h want 0", changed, alland, allor); else n_pass++;
        rst = 1'b0;
        for (int s = 0; s < 5; s++) cyc(1'b1, s == 0, W'(s + 1), 1'b0, 1'b0);
        n_chk++; if (locked !== 1'b1) $display("FAIL lock_set got=%b want 1", locked); else n_pass++;
        rst = 1'b1;
        #2;
        n_chk++; if (locked !== 1'b0 || live !== '0) $display("FAIL midframe_reset locked=%b live=%h want 0", locked, live); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_frame();
        for (int s = 0; s < S; s++) fr[s] = W'(s + 1);
        send_frame(-1, 1'b0);
        n_chk++; if (live[6*W +: W] !== W'(13)) $display("FAIL idx6 got=%0d want 13", live[6*W +: W]); else n_pass++;
        n_chk++; if (live !== exp_live()) $display("FAIL frame_live got=%h want %h", live, exp_live()); else n_pass++;
        n_chk++; if (fd_n !== 1 || m_fd_n !== 1) $display("FAIL frame_done_cnt got=%0d want 1", fd_n); else n_pass++;
        n_chk++; if (snap_vld !== 1'b1 || snap !== exp_snap()) $display("FAIL frame_snap vld=%b snap=%h want 1 %h", snap_vld, snap, exp_snap()); else n_pass++;
    endtask

    task automatic test_cen_toggle();
        int fd0;
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        fd0 = fd_n;
        for (int s = 0; s < S; s++) begin
            cyc(1'b1, s == 0, W'(s + 1), 1'b0, 1'b0);
            cyc(1'b0, 1'($urandom), W'($urandom), 1'b0, 1'b0);
        end
        n_chk++; if (fd_n !== fd0 + 1) $display("FAIL toggle_fd got=%0d want %0d", fd_n, fd0 + 1); else n_pass++;
        n_chk++; if (live !== exp_live() || live[6*W +: W] !== W'(13)) $display("FAIL toggle_live got=%h want %h", live, exp_live()); else n_pass++;
        n_chk++; if (changed !== '0) $display("FAIL toggle_chg got=%h want 0", changed); else n_pass++;
        n_chk++; if (snap_vld !== 1'b1 || snap !== exp_snap()) $display("FAIL toggle_snap vld=%b snap=%h want 1 %h", snap_vld, snap, exp_snap()); else n_pass++;
    endtask

    task automatic test_resync();
        int se0;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        se0 = se_n;
        for (int s = 0; s < 5; s++) cyc(1'b1, s == 0, W'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, W'($urandom), 1'b0, 1'b0);
        for (int s = 1; s < S; s++) cyc(1'b1, 1'b0, W'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int s = 0; s < S; s++) fr[s] = W'($urandom);
        send_frame(-1, 1'b0);
        n_chk++; if (se_n !== se0 + 1 || m_se_n !== 1) $display("FAIL sync_err_cnt got=%0d want %0d", se_n - se0, 1); else n_pass++;
        n_chk++; if (live !== exp_live()) $display("FAIL resync_live got=%h want %h", live, exp_live()); else n_pass++;
        n_chk++; if (fd_n !== m_fd_n) $display("FAIL resync_fd got=%0d want %0d", fd_n, m_fd_n); else n_pass++;
    endtask

    task automatic test_overrun();
        int ovr0;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        ovr0 = ovr_n;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < S; s++) fr[s] = W'($urandom);
            send_frame(-1, 1'b0);
        end
        n_chk++; if (ovr_n !== ovr0 + 1 || ovr_n !== m_ovr_n) $display("FAIL overrun_cnt got=%0d want %0d", ovr_n - ovr0, 1); else n_pass++;
        n_chk++; if (snap !== exp_snap() || snap === live) $display("FAIL overrun_hold snap=%h want %h", snap, exp_snap()); else n_pass++;
        for (int s = 0; s < S; s++) fr[s] = W'($urandom);
        send_frame(-1, 1'b1);
        n_chk++; if (snap !== exp_live() || snap !== exp_snap()) $display("FAIL ack_at_end snap=%h want %h", snap, exp_live()); else n_pass++;
        n_chk++; if (snap_vld !== 1'b1 || ovr_n !== m_ovr_n) $display("FAIL ack_at_end_vld vld=%b ovr=%0d want 1 %0d", snap_vld, ovr_n, m_ovr_n); else n_pass++;
    endtask

    task automatic test_changed();
        for (int s = 0; s < S; s++) fr[s] = W'(s + 1);
        send_frame(-1, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
        send_frame(-1, 1'b1);
        n_chk++; if (changed !== '0) $display("FAIL chg_same got=%h want 0", changed); else n_pass++;
        fr[3] = 10'h155;
        send_frame(-1, 1'b1);
        n_chk++; if (changed !== 24'h000008 || changed !== m_chg) $display("FAIL chg_slot3 got=%h want 000008", changed); else n_pass++;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        n_chk++; if (changed !== '0) $display("FAIL chg_clr got=%h want 0", changed); else n_pass++;
        fr[3] = W'(4);
        send_frame(3, 1'b1);
        n_chk++; if (changed !== 24'h000008 || changed !== m_chg) $display("FAIL chg_set_beats_clr got=%h want 000008", changed); else n_pass++;
    endtask

    task automatic test_reduce();
        logic [W-1:0] ea, eo;
        for (int s = 0; s < S; s++) fr[s] = W'($urandom);
        fr[0] = 10'h3F0; fr[1] = 10'h0FF;
        send_frame(-1, 1'b1);
        mask = 24'h000003;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        n_chk++; if (alland !== 10'h0F0 || allor !== 10'h3FF) $display("FAIL red_mask3 and=%h or=%h want 0f0 3ff", alland, allor); else n_pass++;
        for (int r = 0; r < 4; r++) begin
            mask = S'($urandom);
            ea = '1; eo = '0;
            for (int i = 0; i < S; i++) if (mask[i]) begin ea = ea & m_live[i]; eo = eo | m_live[i]; end
            cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
            n_chk++; if (alland !== ea || allor !== eo) $display("FAIL red_rand and=%h or=%h want %h %h", alland, allor, ea, eo); else n_pass++;
        end
        mask = '0;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        n_chk++; if (alland !== 10'h3FF || allor !== 10'h000) $display("FAIL red_mask0 and=%h or=%h want 3ff 000", alland, allor); else n_pass++;
    endtask

    task automatic test_small();
        logic [SB*W-1:0] e;
        for (int s = 0; s < SB; s++) begin
            cyc_b(1'b1, s == 0, W'(s + 1));
            e[s*W +: W] = W'(s + 1);
        end
        cyc_b(1'b0, 1'b0, '0);
        n_chk++; if (live_b !== e) $display("FAIL small_live got=%h want %h", live_b, e); else n_pass++;
        n_chk++; if (fdb_n !== 1 || locked_b !== 1'b1) $display("FAIL small_fd cnt=%0d locked=%b want 1 1", fdb_n, locked_b); else n_pass++;
        n_chk++; if (snap_vld_b !== 1'b1 || snap_b !== e) $display("FAIL small_snap vld=%b snap=%h want 1 %h", snap_vld_b, snap_b, e); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_cen_toggle();
        test_resync();
        test_overrun();
        test_changed();
        test_reduce();
        test_small();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
